audio_mixer: RTL and testbench

- Sample-rate audio mixer between the YM2149 / ULA beeper sources and the two sigma-delta DACs (AUDIO_L / AUDIO_R).
- Replaces the current wrapping adder expressions with:
  - registered stereo mixing, selectable ABC / ACB / mono;
  - saturation to the DAC width, with a sticky clip flag;
  - a click-free mute/unmute fade state machine.
- All state advances on the 1.75 MHz PSG clock enable (ce_psg).

---
 rtl/audio_mixer.sv | 100 ++++++++++
 tb/tb_audio_mixer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// audio_mixer: registered PSG/beeper stereo mixer with saturation, sticky clip and click-free mute fades.
// Define AUDIO_MIX_LPF_EN to low-pass the beeper through a one-pole IIR before mixing.
module audio_mixer #(
  parameter int W_OUT = 9,
  parameter int FADE_STEP = 4,
  parameter int BEEP_SHIFT = 3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [1:0]       stereo_mode,
  input  logic             mute,
  input  logic [7:0]       ch_a,
  input  logic [7:0]       ch_b,
  input  logic [7:0]       ch_c,
  input  logic             ear,
  input  logic             mic,
  input  logic             tape_in,
  input  logic             clip_clr,
  output logic [W_OUT-1:0] out_l,
  output logic [W_OUT-1:0] out_r,
  output logic             clip,
  output logic             fading
);
  typedef enum logic [1:0] {RUN, FADE_OUT, MUTED, FADE_IN} state_t;
  localparam logic [10:0] SAT = 11'((1 << W_OUT) - 1);
  localparam logic [W_OUT:0] STEP = (W_OUT+1)'(FADE_STEP);
  state_t state, next_state;
  logic [7:0] a, b, c, beep_in, beep;
  logic [1:0] mode;
  logic primed;
  logic [10:0] mono, sum_l, sum_r;
  logic [W_OUT-1:0] tgt_l, tgt_r, fade_l, fade_r;

  assign beep_in = {ear, tape_in, mic, 5'd0};

`ifdef AUDIO_MIX_LPF_EN
  logic [11:0] f;
  logic signed [12:0] delta;
  assign delta = $signed({1'b0, beep_in, 4'd0}) - $signed({1'b0, f});
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) f <= '0;
    else if (ce) f <= f + 12'(delta >>> BEEP_SHIFT);
  assign beep = f[11:4];
`else
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) beep <= '0;
    else if (ce) beep <= beep_in;
`endif

  // Fade arithmetic runs one bit wider so stepping down never wraps below zero.
  function automatic logic [W_OUT-1:0] step_to(input logic [W_OUT-1:0] cur, tgt, input logic down);
    logic [W_OUT:0] x, t;
    x = {1'b0, cur};
    t = {1'b0, tgt};
    return down ? (x > STEP ? W_OUT'(x - STEP) : {W_OUT{1'b0}})
         : x < t ? (t - x > STEP ? W_OUT'(x + STEP) : tgt)
         : (x - t > STEP ? W_OUT'(x - STEP) : tgt);
  endfunction

  always_comb begin
    mono = 11'(a) + 11'(b) + 11'(c) + 11'(beep);
    sum_l = mode == 2'd2 ? mono : {2'b0, a, 1'b0} + 11'(mode == 2'd1 ? c : b) + 11'(beep);
    sum_r = mode == 2'd2 ? mono
          : mode == 2'd1 ? {2'b0, b, 1'b0} + 11'(c) + 11'(beep)
          : {2'b0, c, 1'b0} + 11'(b) + 11'(beep);
    tgt_l = sum_l > SAT ? {W_OUT{1'b1}} : W_OUT'(sum_l);
    tgt_r = sum_r > SAT ? {W_OUT{1'b1}} : W_OUT'(sum_r);
    fade_l = step_to(out_l, tgt_l, mute);
    fade_r = step_to(out_r, tgt_r, mute);
    // primed keeps the power-up fade alive until stage 1 holds real samples.
    next_state = state == RUN ? (mute ? FADE_OUT : RUN)
               : mute ? (fade_l == '0 && fade_r == '0 ? MUTED : FADE_OUT)
               : (primed && fade_l == tgt_l && fade_r == tgt_r ? RUN : FADE_IN);
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      {a, b, c, mode, primed} <= '0;
      out_l <= '0;
      out_r <= '0;
      state <= FADE_IN;
      fading <= 1'b1;
    end else if (ce) begin
      a <= ch_a;
      b <= ch_b;
      c <= ch_c;
      mode <= stereo_mode;
      primed <= 1'b1;
      out_l <= state == RUN ? tgt_l : fade_l;
      out_r <= state == RUN ? tgt_r : fade_r;
      state <= next_state;
      fading <= next_state == FADE_OUT || next_state == FADE_IN;
    end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) clip <= 1'b0;
    else if (ce && (sum_l > SAT || sum_r > SAT)) clip <= 1'b1;
    else if (clip_clr) clip <= 1'b0;
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed stimulus with a scoreboard queue checked by a monitor after every ce.
module tb_audio_mixer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b1, ce = 1'b0, mute = 1'b0, ear = 1'b0, mic = 1'b0, tape_in = 1'b0, clip_clr = 1'b0;
  logic [1:0] stereo_mode = 2'd0;
  logic [7:0] ch_a = 8'd0, ch_b = 8'd0, ch_c = 8'd0;
  logic [8:0] out_l, out_r;
  logic clip, fading;

`ifdef AUDIO_MIX_LPF_EN
  localparam int E1 = 16, MONO = 304, FIN = 127;
  int seq [8] = '{16, 30, 42, 52, 62, 70, 77, 83};
`else
  localparam int E1 = 128, MONO = 332, FIN = 128;
  int seq [8] = '{128, 128, 128, 128, 128, 128, 128, 128};
`endif

  audio_mixer dut (
    .clk_sys(clk), .reset_n(reset_n), .ce(ce), .stereo_mode(stereo_mode), .mute(mute),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ear(ear), .mic(mic), .tape_in(tape_in),
    .clip_clr(clip_clr), .out_l(out_l), .out_r(out_r), .clip(clip), .fading(fading)
  );

  typedef struct packed {logic [3:0] m; logic [8:0] l, r; logic c, f;} exp_t;
  exp_t q[$];
  string nq[$];
  int passed = 0, total = 0;
  logic fired = 1'b0;

  always @(posedge clk) fired <= ce;

  always @(negedge clk)
    if (fired) begin
      exp_t e;
      string n;
      if (q.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: output event with no expected entry");
      end else begin
        e = q.pop_front();
        n = nq.pop_front();
        if (e.m != 4'd0) begin
          total++;
          if ((e.m[3] && out_l !== e.l) || (e.m[2] && out_r !== e.r) ||
              (e.m[1] && clip !== e.c) || (e.m[0] && fading !== e.f))
            $display("FAIL %s: got l=%0d r=%0d clip=%b fading=%b, expected l=%0d r=%0d clip=%b fading=%b (mask %b)",
                     n, out_l, out_r, clip, fading, e.l, e.r, e.c, e.f, e.m);
          else passed++;
        end
      end
    end

  task automatic tick(input string nm, input logic [3:0] m, input int l, r, input logic c, f);
    q.push_back('{m, 9'(l), 9'(r), c, f});
    nq.push_back(nm);
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else passed++;
  endtask

  task automatic areset(input string nm);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk({nm, "_l"}, int'(out_l), 0);
    chk({nm, "_r"}, int'(out_r), 0);
    chk({nm, "_clip"}, int'(clip), 0);
    chk({nm, "_fading"}, int'(fading), 1);
    {ch_a, ch_b, ch_c, stereo_mode, mic, ear, tape_in, mute} = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset("reset");
    ch_a = 8'd100;
    tick("fadein_prime", 4'b1111, 0, 0, 0, 1);
    for (int k = 2; k <= 51; k++) tick("fadein_ramp", 4'b1111, 4 * (k - 1), 0, 0, k < 51);
    tick("fadein_hold", 4'b1111, 200, 0, 0, 0);
    mute = 1'b1;
    tick("mute_enter", 4'b1101, 200, 0, 0, 1);
    for (int i = 1; i <= 20; i++) tick("fadeout", 4'b1101, 200 - 4 * i, 0, 0, 1);
    mute = 1'b0;
    for (int j = 1; j <= 20; j++) tick("fadeback", 4'b1101, 120 + 4 * j, 0, 0, j < 20);
    mute = 1'b1;
    tick("mute2_enter", 4'b1101, 200, 0, 0, 1);
    for (int i = 1; i <= 50; i++) tick("fadeout_full", 4'b1101, 200 - 4 * i, 0, 0, i < 50);
    tick("muted_hold", 4'b1101, 0, 0, 0, 0);
    mute = 1'b0;
    for (int j = 1; j <= 50; j++) tick("unmute", 4'b1101, 4 * j, 0, 0, j < 50);
    ch_a = 8'd10; ch_b = 8'd20; ch_c = 8'd30;
    tick("mode_settle", 4'b0000, 0, 0, 0, 0);
    tick("abc", 4'b1111, 40, 80, 0, 0);
    stereo_mode = 2'd1;
    tick("acb_latency", 4'b1100, 40, 80, 0, 0);
    tick("acb", 4'b1100, 50, 70, 0, 0);
    stereo_mode = 2'd3;
    tick("mode3_latency", 4'b1100, 50, 70, 0, 0);
    tick("mode3_abc", 4'b1100, 40, 80, 0, 0);
    stereo_mode = 2'd2; ch_a = 8'd100; ch_b = 8'd100; ch_c = 8'd100; mic = 1'b1;
    tick("mono_latency", 4'b0000, 0, 0, 0, 0);
    tick("mono", 4'b1111, MONO, MONO, 0, 0);
    areset("async_reset");
    tick("rst_prime", 4'b1111, 0, 0, 0, 1);
    tick("rst_run", 4'b1111, 0, 0, 0, 0);
    ch_a = 8'd255; ch_b = 8'd255; ear = 1'b1;
    tick("clip_latency", 4'b1110, 0, 0, 0, 0);
    tick("clip_sat", 4'b1110, 511, 255 + E1, 1, 0);
    ch_a = 8'd0; ch_b = 8'd0; ear = 1'b0;
    tick("clip_sticky", 4'b1010, 511, 0, 1, 0);
    tick("clip_sticky2", 4'b0010, 0, 0, 1, 0);
    clip_clr = 1'b1;
    @(negedge clk);
    chk("clip_clr", int'(clip), 0);
    clip_clr = 1'b0;
    tick("clip_stays_clear", 4'b0010, 0, 0, 0, 0);
    areset("reset_filter");
    tick("beep_prime", 4'b1111, 0, 0, 0, 1);
    tick("beep_run", 4'b1111, 0, 0, 0, 0);
    ear = 1'b1;
    tick("beep_latency", 4'b1100, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) tick("beep_step", 4'b1100, seq[k], seq[k], 0, 0);
    repeat (100) tick("beep_settle", 4'b0000, 0, 0, 0, 0);
    tick("beep_final", 4'b1111, FIN, FIN, 0, 0);
    chk("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
